conv_dot_engine_19: RTL and testbench

- Consumer directly downstream of the layer weight store. It takes the 288-word weight vector once the store flags it valid, as 32 output channels x 9 taps.
- For each accepted 3x3 input window (9 words), produces 32 channel results, one per cycle, over a valid/ready stream.
- Feeds the activation/feature-map write stage.

---
 rtl/conv_dot_engine_19_pkg.sv | 43 ++++
 rtl/conv_dot_engine_19_dot9_sat.sv | 46 ++++
 rtl/conv_dot_engine_19.sv | 117 +++++++++++
 tb/tb_conv_dot_engine_19.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_dot_engine_19_pkg.sv
// rtl/conv_dot_engine_19_pkg.sv - shared widths, constants and saturation helper for conv_dot_engine_19
//
// Purpose: common definitions for the 3x3 convolution dot-product engine.
//   DW        : signed fixed-point word width
//   NCH/NTAP  : 32 output channels x 9 taps = 288 weight words per set
//   ACC_W     : accumulator width, 9 full-width products cannot overflow it
//   sat_to_dw : clamp a shifted accumulator into the DW output range

package conv_dot_engine_19_pkg;

  localparam int DW       = 16;
  localparam int NCH      = 32;
  localparam int NTAP     = 9;
  localparam int FRAC_DEF = 8;
  localparam int ACC_W    = 2*DW + 4;
  localparam int CH_W     = 5;
  localparam int WQ_W     = NCH*NTAP*DW;
  localparam int WIN_W    = NTAP*DW;

  // Output range limits, both at accumulator width (for comparison) and at
  // output width (for the clamped value).
  localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]           OUT_MAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]           OUT_MIN     = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  function automatic logic [DW-1:0] sat_to_dw(input logic signed [ACC_W-1:0] v);
    logic [DW-1:0] r;
    if (v > ACC_SAT_MAX)
      r = OUT_MAX;
    else if (v < ACC_SAT_MIN)
      r = OUT_MIN;
    else
      r = v[DW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/conv_dot_engine_19_dot9_sat.sv
// rtl/conv_dot_engine_19_dot9_sat.sv - combinational 9-tap signed MAC with shift, saturate and optional ReLU
//
// Purpose: res = relu?(sat(sum_j(w[j]*x[j]) >>> FRAC))
// Ports:
//   w_vec : 9 signed weights, tap j at [j*DW +: DW]
//   x_vec : 9 signed inputs,  tap j at [j*DW +: DW]
//   res   : saturated (and optionally ReLU-clamped) DW-bit result

module conv_dot_engine_19_dot9_sat
  import conv_dot_engine_19_pkg::*;
#(
  parameter int FRAC = FRAC_DEF,
  parameter bit RELU = 1'b0
) (
  input  logic [WIN_W-1:0] w_vec,
  input  logic [WIN_W-1:0] x_vec,
  output logic [DW-1:0]    res
);

  logic signed [2*DW-1:0]  w_ext;
  logic signed [2*DW-1:0]  x_ext;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic [DW-1:0]           sat;

  always_comb begin
    w_ext = '0;
    x_ext = '0;
    prod  = '0;
    acc   = '0;
    for (int j = 0; j < NTAP; j++) begin
      // Operands are sign-extended to the product width first so the
      // multiply is a plain same-width signed product.
      w_ext = {{DW{w_vec[j*DW+DW-1]}}, w_vec[j*DW +: DW]};
      x_ext = {{DW{x_vec[j*DW+DW-1]}}, x_vec[j*DW +: DW]};
      prod  = w_ext * x_ext;
      acc   = acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end
    // Arithmetic shift rounds toward minus infinity.
    shifted = acc >>> FRAC;
    sat     = sat_to_dw(shifted);
    res     = (RELU && sat[DW-1]) ? '0 : sat;
  end

endmodule

// File: rtl/conv_dot_engine_19.sv
// rtl/conv_dot_engine_19.sv - 3x3 window x 32-channel dot-product engine with valid/ready result stream
//
// Purpose: accepts one 9-word window while the weight set is valid, then emits
// one saturated channel result per cycle for channels 0..NCH-1.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   w_valid, w_q       : weight set (channel k tap j = word k*9+j) and its valid level
//   in_valid, in_ready : window handshake; in_win holds taps x0..x8
//   out_valid, out_ready, out_data, out_ch, out_last : result stream
//   busy               : window in progress

module conv_dot_engine_19
  import conv_dot_engine_19_pkg::*;
#(
  parameter int FRAC = FRAC_DEF,
  parameter bit RELU = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_valid,
  input  logic [WQ_W-1:0]  w_q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIN_W-1:0] in_win,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_last,
  output logic             busy
);

  state_t           state;
  logic [CH_W-1:0]  ch;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] w_sel;
  logic [DW-1:0]    res;
  logic             accept;
  logic             load;
  logic             last_ch;

  // Channel select: pick the 9 weights of the current channel from w_q.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch == CH_W'(k))
        w_sel = w_q[k*WIN_W +: WIN_W];
    end
  end

  conv_dot_engine_19_dot9_sat #(
    .FRAC (FRAC),
    .RELU (RELU)
  ) u_dot9 (
    .w_vec (w_sel),
    .x_vec (win_q),
    .res   (res)
  );

  // rst_n gates in_ready so it drops the moment reset asserts, even though
  // the IDLE state itself would otherwise allow an accept.
  assign in_ready = rst_n && w_valid && (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign load     = (state == ST_CALC) && w_valid && (!out_valid || out_ready);
  assign last_ch  = (ch == CH_W'(NCH-1));
  assign busy     = (state == ST_CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ch        <= '0;
      win_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (!w_valid) begin
      // Weight set withdrawn: drop the partial window and any pending result.
      state     <= ST_IDLE;
      ch        <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            win_q <= in_win;
            ch    <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (load) begin
            if (last_ch) begin
              ch    <= '0;
              state <= ST_IDLE;
            end else begin
              ch <= ch + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // The last channel may still sit here after the FSM is back in IDLE;
      // it drains independently of a new accept.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_ch    <= ch;
        out_last  <= last_ch;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_dot_engine_19.sv
// tb/tb_conv_dot_engine_19.sv - directed self-checking bench for conv_dot_engine_19

module tb_conv_dot_engine_19;
  import conv_dot_engine_19_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             w_valid;
  logic [WQ_W-1:0]  w_q;
  logic             in_valid;
  logic [WIN_W-1:0] in_win;
  logic             out_ready;

  logic             in_ready, out_valid, out_last, busy;
  logic [DW-1:0]    out_data;
  logic [CH_W-1:0]  out_ch;

  logic             r_in_ready, r_out_valid, r_out_last, r_busy;
  logic [DW-1:0]    r_out_data;
  logic [CH_W-1:0]  r_out_ch;

  logic [DW-1:0]    wm [NCH][NTAP];
  logic [DW-1:0]    exp_data [64];
  logic [WIN_W-1:0] win_a, win_b;
  int               res_cyc [64];
  int               acc_cyc [2];
  int               n_tests = 0;
  int               n_fail  = 0;

  always #5 clk = ~clk;

  conv_dot_engine_19 #(.FRAC(8), .RELU(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_q(w_q),
    .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .busy(busy)
  );

  conv_dot_engine_19 #(.FRAC(8), .RELU(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_q(w_q),
    .in_valid(in_valid), .in_ready(r_in_ready), .in_win(in_win),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .out_ch(r_out_ch), .out_last(r_out_last), .busy(r_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic load_weights();
    w_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < NTAP; j++)
        w_q[(k*NTAP+j)*DW +: DW] = wm[k][j];
    w_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ch(input int target);
    int n;
    n = 0;
    while (!(out_valid && out_ch == CH_W'(target)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("wait_ch%0d", target), 64'(n < 100), 64'd1);
  endtask

  // Offers win_a (then win_b) and collects n_win*NCH results, checking each
  // visible result against exp_data. Called at a negedge; cycle 0 is now.
  task automatic run_seq(input int n_win, input bit toggle);
    int idx, acc, cyc;
    bit just;
    logic [DW-1:0] er;
    idx = 0; acc = 0; cyc = 0; just = 1'b0;
    in_win = win_a;
    in_valid = 1'b1;
    while (idx < n_win*NCH && cyc < 400) begin
      if (just) begin
        just = 1'b0;
        if (acc < n_win) in_win = win_b;
        else in_valid = 1'b0;
      end
      out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (in_valid && in_ready) begin
        acc_cyc[acc] = cyc;
        acc++;
        just = 1'b1;
      end
      if (out_valid) begin
        er = exp_data[idx];
        if (er[DW-1]) er = '0;
        check_eq($sformatf("ch[%0d]", idx), 64'(out_ch), 64'(idx % NCH));
        check_eq($sformatf("data[%0d]", idx), 64'(out_data), 64'(exp_data[idx]));
        check_eq($sformatf("last[%0d]", idx), 64'(out_last), 64'(idx % NCH == NCH-1));
        check_eq($sformatf("relu_data[%0d]", idx), 64'(r_out_data), 64'(er));
        check_eq($sformatf("relu_hs[%0d]", idx), 64'({r_out_valid, r_out_ch, r_out_last}),
                 64'({1'b1, CH_W'(idx % NCH), idx % NCH == NCH-1}));
        if (out_ready) begin
          res_cyc[idx] = cyc;
          idx++;
        end
      end
      if (idx < n_win*NCH) begin
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("result_count", 64'(idx), 64'(n_win*NCH));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; w_valid = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_win = '0; w_q = '0;
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < NTAP; j++)
        wm[k][j] = 16'h0100;
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < NTAP; j++)
        w_q[(k*NTAP+j)*DW +: DW] = wm[k][j];

    // Reset state
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_out_data", 64'({out_data, out_ch, out_last}), 64'd0);
    check_eq("rst_relu_side", 64'({r_in_ready, r_busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // All-ones weights and window: 9.0 on every channel, latency check
    for (int j = 0; j < NTAP; j++) win_a[j*DW +: DW] = 16'h0100;
    win_b = win_a;
    for (int k = 0; k < NCH; k++) exp_data[k] = 16'h0900;
    run_seq(1, 1'b0);
    check_eq("ones_first_cyc", 64'(res_cyc[0]), 64'd2);
    check_eq("ones_last_cyc", 64'(res_cyc[31]), 64'd33);
    check_eq("ones_idle_valid", 64'({out_valid, busy}), 64'd0);

    // Channel k weights = k.0, x0 = 2.0 -> 2k
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < NTAP; j++)
        wm[k][j] = DW'(k*256);
    load_weights();
    win_a = '0;
    win_a[0 +: DW] = 16'h0200;
    win_b = win_a;
    for (int k = 0; k < NCH; k++) exp_data[k] = DW'(k*512);
    run_seq(1, 1'b0);

    // Saturation both ways; ReLU instance clamps the negative ones
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < NTAP; j++)
        wm[k][j] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
    load_weights();
    for (int j = 0; j < NTAP; j++) win_a[j*DW +: DW] = 16'h7FFF;
    win_b = win_a;
    for (int k = 0; k < NCH; k++) exp_data[k] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
    run_seq(1, 1'b0);

    // Signed results with floor shift, out_ready toggled 1,0,0,1
    for (int k = 0; k < NCH; k++) begin
      for (int j = 0; j < NTAP; j++) wm[k][j] = 16'h0000;
      wm[k][0] = DW'((k-16)*256);
      wm[k][1] = 16'hFFFF;
    end
    load_weights();
    for (int j = 0; j < NTAP; j++) win_a[j*DW +: DW] = 16'h0100;
    win_a[0 +: DW]  = 16'h0180;
    win_a[DW +: DW] = 16'h0001;
    win_b = win_a;
    for (int k = 0; k < NCH; k++) exp_data[k] = DW'((k-16)*384 - 1);
    run_seq(1, 1'b1);

    // Reset while mid-window
    in_win = win_a; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_ch(10);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_rel_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    run_seq(1, 1'b0);

    // Weight invalidation at channel 15 with in_valid held
    in_win = win_a; in_valid = 1'b1;
    @(negedge clk);
    wait_ch(15);
    w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("wdrop_state[%0d]", i), 64'({out_valid, busy, in_ready}), 64'd0);
    end
    w_valid = 1'b1;
    #1;
    run_seq(1, 1'b0);

    // Back-to-back windows, ramp weights; second window saturates for k>=15
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < NTAP; j++)
        wm[k][j] = DW'(k*256);
    load_weights();
    win_a = '0;
    win_a[0 +: DW] = 16'h0200;
    for (int j = 0; j < NTAP; j++) win_b[j*DW +: DW] = 16'h0100;
    for (int k = 0; k < NCH; k++) begin
      exp_data[k]      = DW'(k*512);
      exp_data[NCH+k]  = (k*2304 > 32767) ? 16'h7FFF : DW'(k*2304);
    end
    run_seq(2, 1'b0);
    check_eq("b2b_second_accept", 64'(acc_cyc[1]), 64'd33);
    check_eq("b2b_first_ch31", 64'(res_cyc[31]), 64'd33);
    check_eq("b2b_second_ch0", 64'(res_cyc[32]), 64'd35);
    check_eq("b2b_second_ch31", 64'(res_cyc[63]), 64'd66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
